// File: rtl/comparador_maxmin_secuencial.sv
// Frame-based signed max/min finder: one shared signed comparator checks each
// sample first against the running maximum, then against the running minimum.
module comparador_maxmin_secuencial #(
  parameter  int N_DATOS = 8,
  parameter  int ANCHO   = 8,
  localparam int IDX_W   = (N_DATOS > 2) ? $clog2(N_DATOS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abortar,
  input  logic signed [ANCHO-1:0] dato,
  input  logic                    dato_valido,
  output logic                    dato_listo,
  output logic                    res_valido,
  input  logic                    res_listo,
  output logic signed [ANCHO-1:0] maximo,
  output logic signed [ANCHO-1:0] minimo,
  output logic [IDX_W-1:0]        idx_max,
  output logic [IDX_W-1:0]        idx_min
);

  typedef enum logic [1:0] {
    ACEPTA    = 2'd0,
    CMP_MAX   = 2'd1,
    CMP_MIN   = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_DATOS - 1);

  estado_t estado_q, estado_d;

  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [ANCHO-1:0] muestra_q, muestra_d;
  logic signed [ANCHO-1:0] maximo_q, maximo_d;
  logic signed [ANCHO-1:0] minimo_q, minimo_d;
  logic [IDX_W-1:0]        idx_max_q, idx_max_d;
  logic [IDX_W-1:0]        idx_min_q, idx_min_d;
  // Holds dato_listo low until the first edge after reset release.
  logic                    listo_en_q, listo_en_d;

  logic signed [ANCHO-1:0] cmp_a, cmp_b;
  logic                    cmp_igual, cmp_mayor, cmp_menor;
  logic                    acepta_dato;

  // Single shared signed comparator; operand b follows the FSM phase.
  always_comb begin
    cmp_a     = muestra_q;
    cmp_b     = (estado_q == CMP_MIN) ? minimo_q : maximo_q;
    cmp_igual = (cmp_a == cmp_b);
    cmp_mayor = (cmp_a > cmp_b);
    cmp_menor = (cmp_a < cmp_b);
  end

  assign acepta_dato = dato_valido && dato_listo && !abortar;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ACEPTA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ACEPTA: begin
        if (acepta_dato && (cnt_q != '0)) begin
          estado_d = CMP_MAX;
        end
      end
      CMP_MAX: estado_d = CMP_MIN;
      CMP_MIN: estado_d = (cnt_q == ULTIMO) ? RESULTADO : ACEPTA;
      RESULTADO: begin
        if (res_listo) begin
          estado_d = ACEPTA;
        end
      end
      default: estado_d = ACEPTA;
    endcase
    if (abortar) begin
      estado_d = ACEPTA;
    end
  end

  // Output logic: both handshake outputs come from registers only.
  always_comb begin
    dato_listo = listo_en_q && (estado_q == ACEPTA);
    res_valido = (estado_q == RESULTADO);
  end

  // Datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    muestra_d  = muestra_q;
    maximo_d   = maximo_q;
    minimo_d   = minimo_q;
    idx_max_d  = idx_max_q;
    idx_min_d  = idx_min_q;
    listo_en_d = 1'b1;
    case (estado_q)
      ACEPTA: begin
        if (acepta_dato) begin
          muestra_d = dato;
          if (cnt_q == '0) begin
            maximo_d  = dato;
            minimo_d  = dato;
            idx_max_d = '0;
            idx_min_d = '0;
            cnt_d     = IDX_W'(1);
          end
        end
      end
      CMP_MAX: begin
        // Strict compare keeps the earliest index on ties.
        if (cmp_mayor && !cmp_igual) begin
          maximo_d  = muestra_q;
          idx_max_d = cnt_q;
        end
      end
      CMP_MIN: begin
        if (cmp_menor && !cmp_igual) begin
          minimo_d  = muestra_q;
          idx_min_d = cnt_q;
        end
        if (cnt_q != ULTIMO) begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      RESULTADO: begin
        if (res_listo) begin
          cnt_d = '0;
        end
      end
      default: cnt_d = '0;
    endcase
    if (abortar) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      muestra_q  <= '0;
      maximo_q   <= '0;
      minimo_q   <= '0;
      idx_max_q  <= '0;
      idx_min_q  <= '0;
      listo_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      muestra_q  <= muestra_d;
      maximo_q   <= maximo_d;
      minimo_q   <= minimo_d;
      idx_max_q  <= idx_max_d;
      idx_min_q  <= idx_min_d;
      listo_en_q <= listo_en_d;
    end
  end

  assign maximo  = maximo_q;
  assign minimo  = minimo_q;
  assign idx_max = idx_max_q;
  assign idx_min = idx_min_q;

endmodule

// File: tb/tb_comparador_maxmin_secuencial.sv
// Bench for comparador_maxmin_secuencial: directed frames plus random traffic,
// scored by a frame-level reference model and a result queue.
module tb_comparador_maxmin_secuencial;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                abortar;
  logic signed [W-1:0] dato;
  logic                dato_valido;
  logic                dato_listo;
  logic                res_valido;
  logic                res_listo;
  logic signed [W-1:0] maximo;
  logic signed [W-1:0] minimo;
  logic [IW-1:0]       idx_max;
  logic [IW-1:0]       idx_min;

  comparador_maxmin_secuencial #(.N_DATOS(N), .ANCHO(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abortar    (abortar),
    .dato       (dato),
    .dato_valido(dato_valido),
    .dato_listo (dato_listo),
    .res_valido (res_valido),
    .res_listo  (res_listo),
    .maximo     (maximo),
    .minimo     (minimo),
    .idx_max    (idx_max),
    .idx_min    (idx_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mx;
    int mn;
    int imx;
    int imn;
  } res_t;

  res_t esperados[$];
  int   trama[$];
  int   checks = 0;
  int   errores = 0;

  task automatic chk(input string nombre, input int act, input int req);
    checks++;
    if (act != req) begin
      errores++;
      $display("FAIL %s got %0d expected %0d at %0t", nombre, act, req, $time);
    end
  endtask

  // Reference: plain scan of the completed frame, strict compare keeps earliest index.
  function automatic res_t modelo(input int v[$]);
    res_t r;
    r.mx = v[0]; r.mn = v[0]; r.imx = 0; r.imn = 0;
    for (int i = 1; i < v.size(); i++) begin
      if (v[i] > r.mx) begin r.mx = v[i]; r.imx = i; end
      if (v[i] < r.mn) begin r.mn = v[i]; r.imn = i; end
    end
    return r;
  endfunction

  // One clock of stimulus; model bookkeeping for the edge that follows.
  task automatic ciclo(input logic v, input int d, input logic ab, input logic rl,
                       output logic acc);
    @(negedge clk);
    dato_valido = v;
    dato        = W'(d);
    abortar     = ab;
    res_listo   = rl && !ab;
    #1;
    acc = 1'b0;
    if (ab) begin
      trama.delete();
      if (esperados.size() > 0) void'(esperados.pop_back());
    end else if (v && dato_listo && rst_n) begin
      acc = 1'b1;
      trama.push_back(int'($signed(W'(d))));
      if (trama.size() == N) begin
        esperados.push_back(modelo(trama));
        trama.delete();
      end
    end
  endtask

  task automatic inactivo(input logic rl);
    logic acc;
    ciclo(1'b0, 0, 1'b0, rl, acc);
  endtask

  task automatic enviar(input int d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) ciclo(1'b1, d, 1'b0, 1'b1, acc);
    if (!acc) chk("enviar_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard whenever a result handshake is presented.
  always @(negedge clk) begin
    res_t e;
    #2;
    if (rst_n && res_valido && res_listo) begin
      if (esperados.size() == 0) begin
        chk("resultado_inesperado", 1, 0);
      end else begin
        e = esperados.pop_front();
        $display("RES max=%0d@%0d min=%0d@%0d", $signed(maximo), idx_max,
                 $signed(minimo), idx_min);
        chk("maximo", int'($signed(maximo)), e.mx);
        chk("minimo", int'($signed(minimo)), e.mn);
        chk("idx_max", int'(idx_max), e.imx);
        chk("idx_min", int'(idx_min), e.imn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   d;
    rst_n = 1'b0; abortar = 1'b0; dato = '0; dato_valido = 1'b0; res_listo = 1'b0;
    #1;
    chk("rst_maximo", int'(maximo), 0);
    chk("rst_minimo", int'(minimo), 0);
    chk("rst_idx", int'({idx_max, idx_min}), 0);
    chk("rst_res_valido", int'(res_valido), 0);
    chk("rst_dato_listo", int'(dato_listo), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Frame with repeated minimum, and exact result latency.
    enviar(5); enviar(-3); enviar(12); enviar(-3);
    inactivo(1'b1); chk("lat_e0", int'(res_valido), 0);
    inactivo(1'b1); chk("lat_e1", int'(res_valido), 0);
    inactivo(1'b1); chk("lat_e2", int'(res_valido), 1);
    inactivo(1'b1); chk("res_un_ciclo", int'(res_valido), 0);

    // Signed extremes, then ties.
    enviar(-128); enviar(127); enviar(0); enviar(-1);
    enviar(7); enviar(7); enviar(7); enviar(7);
    enviar(3); enviar(9); enviar(9); enviar(1);

    // Backpressure with a sample waiting at the input.
    enviar(10); enviar(20); enviar(-30); enviar(5);
    repeat (3) ciclo(1'b1, 55, 1'b0, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      ciclo(1'b1, 55, 1'b0, 1'b0, acc);
      chk("bp_res_valido", int'(res_valido), 1);
      chk("bp_dato_listo", int'(dato_listo), 0);
      chk("bp_maximo", int'($signed(maximo)), 20);
    end
    ciclo(1'b1, 55, 1'b0, 1'b1, acc);
    ciclo(1'b1, 55, 1'b0, 1'b1, acc);
    chk("bp_acepta_siguiente", int'(acc), 1);
    enviar(-2); enviar(60); enviar(55);

    // Abort coincident with the third handshake.
    enviar(40); enviar(-5);
    inactivo(1'b1); inactivo(1'b1);
    ciclo(1'b1, 77, 1'b1, 1'b1, acc);
    chk("abort_coincide_listo", int'(dato_listo), 1);
    enviar(1); enviar(2); enviar(3); enviar(4);
    repeat (4) inactivo(1'b1);

    // Asynchronous reset in CMP_MAX.
    enviar(50); enviar(-50);
    @(posedge clk); #2;
    rst_n = 1'b0;
    trama.delete(); esperados.delete();
    #1;
    chk("arst_maximo", int'(maximo), 0);
    chk("arst_minimo", int'(minimo), 0);
    chk("arst_dato_listo", int'(dato_listo), 0);
    chk("arst_res_valido", int'(res_valido), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_listo_antes", int'(dato_listo), 0);
    @(posedge clk);
    #1 chk("post_rst_listo", int'(dato_listo), 1);
    enviar(-7); enviar(8); enviar(-9); enviar(6);
    repeat (4) inactivo(1'b1);

    // Random traffic with boundary-biased samples.
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 5))
        0:       d = -128;
        1:       d = 127;
        2:       d = int'($urandom_range(0, 3)) - 1;
        default: d = int'($urandom_range(0, 255)) - 128;
      endcase
      ciclo(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0), acc);
    end

    repeat (15) inactivo(1'b1);
    chk("scoreboard_vacio", esperados.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end

endmodule
